// File: rtl/bpred_update_queue.sv
// ============================================================================
// bpred_update_queue : in-order FIFO that replays resolved branches to the
//                      predictor update port, with saturating statistics.
// Revision 1.0
// ============================================================================
`default_nettype none

module bpred_update_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  logic [31:0]                  ex_PC4,
    input  logic [31:0]                  ex_target,
    input  logic                         ex_dir,
    input  logic                         ex_miss,
    input  logic                         ex_recover_ras,
    input  logic [3:0]                   ex_meta,
    input  logic                         soin_bpredictor_stall,
    output logic                         execute_bpredictor_update,
    output logic [31:0]                  execute_bpredictor_PC4,
    output logic [31:0]                  execute_bpredictor_target,
    output logic                         execute_bpredictor_dir,
    output logic                         execute_bpredictor_miss,
    output logic                         execute_bpredictor_recover_ras,
    output logic [3:0]                   execute_bpredictor_meta,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             stat_updates,
    output logic [CNT_W-1:0]             stat_misses
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 71;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_stat_upd;
    logic [CNT_W-1:0]   r_stat_miss;

    logic               w_empty;
    logic               w_enq;
    logic               w_deq;
    logic [ENTRY_W-1:0] w_head;

    // Ready is derived from registered occupancy only, so stall never reaches ex_ready.
    assign w_empty  = (r_occ == '0);
    assign ex_ready = (r_occ != OCC_W'(DEPTH));
    assign w_enq    = ex_valid & ex_ready;
    assign w_deq    = ~w_empty & ~soin_bpredictor_stall;
    assign w_head   = w_empty ? '0 : r_mem[r_rd_ptr];

    assign execute_bpredictor_update      = w_deq;
    assign execute_bpredictor_PC4         = w_head[70:39];
    assign execute_bpredictor_target      = w_head[38:7];
    assign execute_bpredictor_dir         = w_head[6];
    assign execute_bpredictor_miss        = w_head[5];
    assign execute_bpredictor_recover_ras = w_head[4];
    assign execute_bpredictor_meta        = w_head[3:0];

    assign occupancy    = r_occ;
    assign stat_updates = r_stat_upd;
    assign stat_misses  = r_stat_miss;

    // Storage is deliberately left out of reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {ex_PC4, ex_target, ex_dir, ex_miss, ex_recover_ras, ex_meta};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_upd  <= '0;
            r_stat_miss <= '0;
        end else if (w_deq) begin
            if (r_stat_upd != '1) begin
                r_stat_upd <= r_stat_upd + CNT_W'(1);
            end
            if (w_head[5] && (r_stat_miss != '1)) begin
                r_stat_miss <= r_stat_miss + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
